// File: rtl/rat_flag_int_unit.sv
// rat_flag_int_unit
// -----------------
// Flag-and-interrupt context unit for the RAT CPU. Holds the carry (C) and
// zero (Z) flags, their shadow copies used across an interrupt, and the
// interrupt-enable (I) flag. Latches rising edges of the external interrupt
// request and implements the save/restore half of the interrupt protocol:
// flags are snapshotted when the control unit accepts an interrupt and
// restored on return.
//
// Build option:
//   RAT_INT_SYNC_EN  defined   -> INT_REQ passes a 2-flop synchronizer
//                                 (pend set two edges after first sample)
//                    undefined -> INT_REQ feeds the edge register directly
//                                 (only for requests synchronous to clk)
//
// Ports:
//   clk      in   system clock, rising edge
//   RST      in   asynchronous active-high reset
//   C_IN     in   ALU carry result
//   Z_IN     in   ALU zero result
//   C_LD     in   load C_IN into C
//   Z_LD     in   load Z_IN into Z
//   C_SET    in   force C to 1
//   C_CLEAR  in   force C to 0
//   SEI      in   set I flag
//   CLI      in   clear I flag
//   INT_REQ  in   external interrupt request (level)
//   INT_ACK  in   control unit enters the interrupt vector cycle
//   RETI     in   return from interrupt
//   RETI_IE  in   I value after RETI (1 = RETIE, 0 = RETID)
//   C_FLAG   out  current carry
//   Z_FLAG   out  current zero
//   I_FLAG   out  interrupt enable
//   INT_PEND out  serviceable interrupt present
//   IN_ISR   out  high while the handler is executing

module rat_flag_int_unit (
  input  logic clk,
  input  logic RST,
  input  logic C_IN,
  input  logic Z_IN,
  input  logic C_LD,
  input  logic Z_LD,
  input  logic C_SET,
  input  logic C_CLEAR,
  input  logic SEI,
  input  logic CLI,
  input  logic INT_REQ,
  input  logic INT_ACK,
  input  logic RETI,
  input  logic RETI_IE,
  output logic C_FLAG,
  output logic Z_FLAG,
  output logic I_FLAG,
  output logic INT_PEND,
  output logic IN_ISR
);

  typedef enum logic {
    RUN = 1'b0,
    ISR = 1'b1
  } state_t;

  state_t state, state_next;

  logic shadow_c, shadow_z;
  logic pend, req_d;
  logic req_s, req_rise;
  logic ack_take, reti_take;

  logic c_next, z_next, i_next;
  logic shadow_c_next, shadow_z_next;
  logic pend_next;

`ifdef RAT_INT_SYNC_EN
  logic sync1, sync2;

  // Two-stage synchronizer bringing the asynchronous request into clk domain.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= INT_REQ;
      sync2 <= sync1;
    end
  end

  assign req_s = sync2;
`else
  assign req_s = INT_REQ;
`endif

  // A held-high request produces a single rise, so only one pend is raised.
  assign req_rise = req_s & ~req_d;

  assign INT_PEND  = pend & I_FLAG & (state == RUN);
  assign IN_ISR    = (state == ISR);

  // An ACK only counts when an interrupt is actually serviceable, and RETI
  // only counts inside a handler; anything else is ignored.
  assign ack_take  = INT_ACK & INT_PEND;
  assign reti_take = RETI & (state == ISR);

  // Next-state and next-flag logic. ACK save beats RETI restore beats the
  // ordinary flag writers.
  always_comb begin
    state_next    = state;
    c_next        = C_FLAG;
    z_next        = Z_FLAG;
    i_next        = I_FLAG;
    shadow_c_next = shadow_c;
    shadow_z_next = shadow_z;

    if (ack_take) begin
      shadow_c_next = C_FLAG;
      shadow_z_next = Z_FLAG;
      i_next        = 1'b0;
      state_next    = ISR;
    end else if (reti_take) begin
      c_next     = shadow_c;
      z_next     = shadow_z;
      i_next     = RETI_IE;
      state_next = RUN;
    end else begin
      if (C_CLEAR)
        c_next = 1'b0;
      else if (C_SET)
        c_next = 1'b1;
      else if (C_LD)
        c_next = C_IN;

      if (Z_LD)
        z_next = Z_IN;

      if (CLI)
        i_next = 1'b0;
      else if (SEI)
        i_next = 1'b1;
    end

    // A fresh edge in the ACK cycle keeps pend set so it is not lost.
    pend_next = req_rise | (pend & ~ack_take);
  end

  // State, flag, shadow and request registers.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state    <= RUN;
      C_FLAG   <= 1'b0;
      Z_FLAG   <= 1'b0;
      I_FLAG   <= 1'b0;
      shadow_c <= 1'b0;
      shadow_z <= 1'b0;
      pend     <= 1'b0;
      req_d    <= 1'b0;
    end else begin
      state    <= state_next;
      C_FLAG   <= c_next;
      Z_FLAG   <= z_next;
      I_FLAG   <= i_next;
      shadow_c <= shadow_c_next;
      shadow_z <= shadow_z_next;
      pend     <= pend_next;
      req_d    <= req_s;
    end
  end

endmodule

// File: tb/tb_rat_flag_int_unit.sv
// tb_rat_flag_int_unit
// --------------------
// Self-checking bench for rat_flag_int_unit: a directed vector table, hand
// sequences for the interrupt corner cases, and a randomized phase compared
// against a behavioural model. Works for either build of RAT_INT_SYNC_EN.

module tb_rat_flag_int_unit;

`ifdef RAT_INT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  // Stimulus bit positions: {c_in,z_in,c_ld,z_ld,c_set,c_clear,sei,cli,
  //                          int_req,int_ack,reti,reti_ie}
  localparam logic [11:0] CIN  = 12'b1000_0000_0000;
  localparam logic [11:0] ZIN  = 12'b0100_0000_0000;
  localparam logic [11:0] CLD  = 12'b0010_0000_0000;
  localparam logic [11:0] ZLD  = 12'b0001_0000_0000;
  localparam logic [11:0] CSET = 12'b0000_1000_0000;
  localparam logic [11:0] CCLR = 12'b0000_0100_0000;
  localparam logic [11:0] SEIB = 12'b0000_0010_0000;
  localparam logic [11:0] CLIB = 12'b0000_0001_0000;
  localparam logic [11:0] REQ  = 12'b0000_0000_1000;
  localparam logic [11:0] ACK  = 12'b0000_0000_0100;
  localparam logic [11:0] RET  = 12'b0000_0000_0010;
  localparam logic [11:0] RIE  = 12'b0000_0000_0001;
  localparam logic [11:0] NONE = 12'b0;

  // Expected outputs are packed {C, Z, I, INT_PEND, IN_ISR}.
  typedef struct {
    logic [11:0] stim;
    logic [4:0]  exp;
  } vec_t;

  logic clk, RST;
  logic c_in, z_in, c_ld, z_ld, c_set, c_clear, sei, cli;
  logic int_req, int_ack, reti, reti_ie;
  logic c_flag, z_flag, i_flag, int_pend, in_isr;

  int tests = 0;
  int fails = 0;

  rat_flag_int_unit dut (
    .clk(clk), .RST(RST),
    .C_IN(c_in), .Z_IN(z_in), .C_LD(c_ld), .Z_LD(z_ld),
    .C_SET(c_set), .C_CLEAR(c_clear), .SEI(sei), .CLI(cli),
    .INT_REQ(int_req), .INT_ACK(int_ack), .RETI(reti), .RETI_IE(reti_ie),
    .C_FLAG(c_flag), .Z_FLAG(z_flag), .I_FLAG(i_flag),
    .INT_PEND(int_pend), .IN_ISR(in_isr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: flags follow the written priority rules directly,
  // and the request path is a history of sampled INT_REQ values where a new
  // request is a 0->1 step seen LAT samples late.
  logic m_c, m_z, m_i, m_sc, m_sz, m_pend, m_isr;
  logic hist[$];

  always @(posedge clk or posedge RST) begin
    if (RST) begin
      m_c = 0; m_z = 0; m_i = 0; m_sc = 0; m_sz = 0; m_pend = 0; m_isr = 0;
      hist.delete();
      for (int k = 0; k < LAT + 2; k++) hist.push_back(1'b0);
    end else begin
      logic serviceable, take_ack, take_reti, new_req;
      serviceable = m_pend && m_i && !m_isr;
      take_ack    = int_ack && serviceable;
      take_reti   = reti && m_isr;
      hist.push_front(int_req);
      void'(hist.pop_back());
      new_req = hist[LAT] && !hist[LAT+1];
      if (take_ack) begin
        m_sc = m_c; m_sz = m_z; m_i = 0; m_isr = 1;
      end else if (take_reti) begin
        m_c = m_sc; m_z = m_sz; m_i = reti_ie; m_isr = 0;
      end else begin
        if (c_clear) m_c = 0;
        else if (c_set) m_c = 1;
        else if (c_ld) m_c = c_in;
        if (z_ld) m_z = z_in;
        if (cli) m_i = 0;
        else if (sei) m_i = 1;
      end
      m_pend = new_req || (m_pend && !take_ack);
    end
  end

  task automatic applyStimulus(input logic [11:0] s);
    {c_in, z_in, c_ld, z_ld, c_set, c_clear, sei, cli,
     int_req, int_ack, reti, reti_ie} = s;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [4:0] exp);
    logic [4:0] got;
    got = {c_flag, z_flag, i_flag, int_pend, in_isr};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got CZIPS=%b expected %b", name, got, exp);
    end
  endtask

  task automatic run(input string name, input logic [11:0] s, input logic [4:0] e);
    applyStimulus(s);
    checkOutput(name, e);
  endtask

  vec_t tbl[14];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0]  = '{CIN|CLD|CSET|CCLR, 5'b00000};
    tbl[1]  = '{CSET|CLD,          5'b10000};
    tbl[2]  = '{ZIN|ZLD,           5'b11000};
    tbl[3]  = '{CLD,               5'b01000};
    tbl[4]  = '{CSET,              5'b11000};
    tbl[5]  = '{SEIB|CLIB,         5'b11000};
    tbl[6]  = '{SEIB,              5'b11100};
    tbl[7]  = '{CLIB,              5'b11000};
    tbl[8]  = '{RET|RIE,           5'b11000};
    tbl[9]  = '{ZLD,               5'b10000};
    tbl[10] = '{SEIB,              5'b10100};
    tbl[11] = '{RET,               5'b10100};
    tbl[12] = '{ACK,               5'b10100};
    tbl[13] = '{CCLR|CIN|CLD,      5'b00100};

    RST = 1'b1;
    {c_in, z_in, c_ld, z_ld, c_set, c_clear, sei, cli,
     int_req, int_ack, reti, reti_ie} = NONE;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_state", 5'b00000);
    RST = 1'b0;

    for (int n = 0; n < 14; n++)
      run($sformatf("table_%0d", n), tbl[n].stim, tbl[n].exp);

    // Interrupt round trip with save/restore of C=1, Z=0.
    run("rt_setc", CSET, 5'b10100);
    for (int j = 0; j <= LAT; j++)
      run($sformatf("rt_latency_%0d", j), (j == 0) ? REQ : NONE,
          {3'b101, logic'(j == LAT), 1'b0});
    run("rt_ack", ACK|CLD, 5'b10001);
    run("rt_isr_load", CLD|ZIN|ZLD, 5'b01001);
    run("rt_retie", RET|RIE, 5'b10100);

    // Masking: request pends while I=0, becomes visible on SEI.
    run("mask_cli", CLIB, 5'b10000);
    for (int j = 0; j <= LAT + 1; j++)
      run($sformatf("mask_wait_%0d", j), (j == 0) ? REQ : NONE, 5'b10000);
    run("mask_sei_cli", SEIB|CLIB, 5'b10000);
    run("mask_sei", SEIB, 5'b10110);
    run("mask_ack", ACK, 5'b10001);

    // Nesting: an edge during the ISR stays pending, ACK in ISR ignored.
    for (int j = 0; j <= LAT + 1; j++)
      run($sformatf("nest_wait_%0d", j), (j == 0) ? REQ : NONE, 5'b10001);
    run("nest_ack_ignored", ACK, 5'b10001);
    run("nest_retie", RET|RIE, 5'b10110);
    run("nest_ack2", ACK, 5'b10001);
    run("nest_retid", RET, 5'b10000);

    // Held request produces a single service.
    run("held_sei", SEIB, 5'b10100);
    for (int j = 0; j <= LAT; j++)
      run($sformatf("held_rise_%0d", j), REQ, {3'b101, logic'(j == LAT), 1'b0});
    run("held_ack", ACK|REQ, 5'b10001);
    run("held_retie", RET|RIE|REQ, 5'b10100);
    for (int j = 0; j < 4; j++)
      run($sformatf("held_high_%0d", j), REQ, 5'b10100);
    for (int j = 0; j <= LAT + 1; j++)
      run($sformatf("held_fall_%0d", j), NONE, 5'b10100);

    // Reset in the middle of an ISR with a request pending.
    for (int j = 0; j <= LAT; j++)
      run($sformatf("rst_pre_%0d", j), (j == 0) ? REQ : NONE,
          {3'b101, logic'(j == LAT), 1'b0});
    run("rst_ack", ACK, 5'b10001);
    run("rst_isr_setup", SEIB|ZIN|ZLD, 5'b11101);
    for (int j = 0; j <= LAT + 1; j++)
      run($sformatf("rst_isr_req_%0d", j), (j == 0) ? REQ : NONE, 5'b11101);
    #2 RST = 1'b1;
    #1 checkOutput("rst_async", 5'b00000);
    @(negedge clk);
    RST = 1'b0;
    run("rst_after_sei", SEIB, 5'b00100);
    run("rst_stray_reti", RET|RIE, 5'b00100);
    run("rst_ack_ignored", ACK, 5'b00100);

    // Randomized phase against the behavioural model.
    begin
      logic req_level;
      logic [11:0] s;
      req_level = 1'b0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(0, 5) == 0) req_level = ~req_level;
        s = 12'($urandom) & ~(REQ | ACK | RET);
        if ($urandom_range(0, 3) != 0) s &= ~(CSET | CCLR | CLIB);
        if (req_level) s |= REQ;
        if ($urandom_range(0, 3) == 0) s |= ACK;
        if ($urandom_range(0, 5) == 0) s |= RET;
        applyStimulus(s);
        checkOutput($sformatf("random_%0d", n),
                    {m_c, m_z, m_i, m_pend & m_i & ~m_isr, m_isr});
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
